// File: rtl/cnu_min_tracker_10.sv
// cnu_min_tracker_10: running min1/min2 tracker around the partial min comparator.
// Define CNU_MIN2_INDEX_EN to expose the registered min2_index output.
module cnu_min_tracker_10 #(
    parameter int CN_DEGREE        = 10,
    parameter int QUAN_SIZE        = 3,
    parameter int ROW_SPLIT_FACTOR = 5,
    parameter int IDX_WIDTH        = 4
) (
    input  logic                 sys_clk,
    input  logic                 rstn,
    input  logic                 v2c_valid,
    output logic                 v2c_ready,
    input  logic [QUAN_SIZE-1:0] v2c_msg_0,
    input  logic [QUAN_SIZE-1:0] v2c_msg_1,
    input  logic [1:0]           is_min_0_in,
    input  logic [1:0]           is_min_1_in,
    input  logic                 min_index_newIn_set,
    output logic [QUAN_SIZE-1:0] fb_msg_0,
    output logic [QUAN_SIZE-1:0] fb_msg_1,
    output logic                 fb_min_index,
    output logic                 first_comp,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [QUAN_SIZE-1:0] min1,
    output logic [QUAN_SIZE-1:0] min2,
    output logic [IDX_WIDTH-1:0] min1_index,
`ifdef CNU_MIN2_INDEX_EN
    output logic [IDX_WIDTH-1:0] min2_index,
`endif
    input  logic                 flush
);
    localparam int CW   = $clog2(ROW_SPLIT_FACTOR);
    localparam int PAIR = CN_DEGREE / ROW_SPLIT_FACTOR;

    logic [CW-1:0]        beat_cnt;
    logic [QUAN_SIZE-1:0] min1_r, min2_r;
    logic [IDX_WIDTH-1:0] idx1_r, idx2_r, base;
    logic [QUAN_SIZE-1:0] c_val [4];
    logic [IDX_WIDTH-1:0] c_idx [4];
    logic                 accept, last;

    assign v2c_ready    = ~out_valid | out_ready;
    assign accept       = v2c_valid & v2c_ready;
    assign last         = beat_cnt == CW'(ROW_SPLIT_FACTOR - 1);
    assign first_comp   = beat_cnt == '0;
    assign fb_msg_0     = min1_r;
    assign fb_msg_1     = min2_r;
    assign fb_min_index = 1'b0;
    assign base         = IDX_WIDTH'(PAIR * beat_cnt);

    // Candidate order matches the comparator select encoding.
    always_comb begin
        c_val[0] = min_index_newIn_set ? v2c_msg_1 : v2c_msg_0;
        c_val[1] = min_index_newIn_set ? v2c_msg_0 : v2c_msg_1;
        c_val[2] = min1_r;
        c_val[3] = min2_r;
        c_idx[0] = base | IDX_WIDTH'(min_index_newIn_set);
        c_idx[1] = base | IDX_WIDTH'(~min_index_newIn_set);
        c_idx[2] = idx1_r;
        c_idx[3] = idx2_r;
    end

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            beat_cnt   <= '0;
            min1_r     <= '1;
            min2_r     <= '1;
            idx1_r     <= '0;
            idx2_r     <= '0;
            out_valid  <= 1'b0;
            min1       <= '1;
            min2       <= '1;
            min1_index <= '0;
`ifdef CNU_MIN2_INDEX_EN
            min2_index <= '0;
`endif
        end else begin
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            if (flush) begin
                beat_cnt <= '0;
                min1_r   <= '1;
                min2_r   <= '1;
                idx1_r   <= '0;
                idx2_r   <= '0;
            end else if (accept) begin
                idx1_r <= c_idx[is_min_0_in];
                idx2_r <= c_idx[is_min_1_in];
                if (last) begin
                    beat_cnt   <= '0;
                    min1_r     <= '1;
                    min2_r     <= '1;
                    out_valid  <= 1'b1;
                    min1       <= c_val[is_min_0_in];
                    min2       <= c_val[is_min_1_in];
                    min1_index <= c_idx[is_min_0_in];
`ifdef CNU_MIN2_INDEX_EN
                    min2_index <= c_idx[is_min_1_in];
`endif
                end else begin
                    beat_cnt <= beat_cnt + 1'b1;
                    min1_r   <= c_val[is_min_0_in];
                    min2_r   <= c_val[is_min_1_in];
                end
            end
        end
    end
endmodule

// File: tb/tb_cnu_min_tracker_10.sv
// tb_cnu_min_tracker_10: directed bench with a behavioural partial min comparator in the loop.
module tb_cnu_min_tracker_10;
    localparam int Q  = 3;
    localparam int IW = 4;

    logic          sys_clk = 1'b0;
    logic          rstn = 1'b0;
    logic          v2c_valid = 1'b0, v2c_ready;
    logic [Q-1:0]  v2c_msg_0 = '0, v2c_msg_1 = '0;
    logic [1:0]    is_min_0_in, is_min_1_in;
    logic          min_index_newIn_set;
    logic [Q-1:0]  fb_msg_0, fb_msg_1;
    logic          fb_min_index, first_comp, out_valid;
    logic          out_ready = 1'b1;
    logic [Q-1:0]  min1, min2;
    logic [IW-1:0] min1_index;
`ifdef CNU_MIN2_INDEX_EN
    logic [IW-1:0] min2_index;
`endif
    logic          flush = 1'b0;

    int tests = 0;
    int fails = 0;
    int row [10];

    always #5 sys_clk = ~sys_clk;

    cnu_min_tracker_10 dut (
        .sys_clk(sys_clk), .rstn(rstn), .v2c_valid(v2c_valid), .v2c_ready(v2c_ready),
        .v2c_msg_0(v2c_msg_0), .v2c_msg_1(v2c_msg_1),
        .is_min_0_in(is_min_0_in), .is_min_1_in(is_min_1_in),
        .min_index_newIn_set(min_index_newIn_set),
        .fb_msg_0(fb_msg_0), .fb_msg_1(fb_msg_1), .fb_min_index(fb_min_index),
        .first_comp(first_comp), .out_valid(out_valid), .out_ready(out_ready),
        .min1(min1), .min2(min2), .min1_index(min1_index),
`ifdef CNU_MIN2_INDEX_EN
        .min2_index(min2_index),
`endif
        .flush(flush)
    );

    // Comparator model: strict less-than, lowest candidate number wins ties.
    logic [Q-1:0] cv [4];
    always_comb begin
        min_index_newIn_set = v2c_msg_1 < v2c_msg_0;
        cv[0] = min_index_newIn_set ? v2c_msg_1 : v2c_msg_0;
        cv[1] = min_index_newIn_set ? v2c_msg_0 : v2c_msg_1;
        cv[2] = fb_msg_0;
        cv[3] = fb_msg_1;
        is_min_0_in = 2'd0;
        for (int i = 1; i < 4; i++)
            if (cv[i] < cv[is_min_0_in]) is_min_0_in = 2'(i);
        is_min_1_in = (is_min_0_in == 2'd0) ? 2'd1 : 2'd0;
        for (int i = 0; i < 4; i++)
            if (2'(i) != is_min_0_in && cv[i] < cv[is_min_1_in]) is_min_1_in = 2'(i);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic beat(input int a, input int b);
        v2c_valid = 1'b1;
        v2c_msg_0 = Q'(a);
        v2c_msg_1 = Q'(b);
        @(posedge sys_clk);
        #1;
        v2c_valid = 1'b0;
    endtask

    task automatic send_row(input int m [10]);
        for (int b = 0; b < 5; b++) begin
            v2c_valid = 1'b1;
            v2c_msg_0 = Q'(m[2*b]);
            v2c_msg_1 = Q'(m[2*b+1]);
            #1;
            check("first_comp", first_comp, b == 0);
            @(posedge sys_clk);
            #1;
        end
        v2c_valid = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_v2c_ready"}, v2c_ready, 1);
        check({tag, "_first_comp"}, first_comp, 1);
        check({tag, "_fb0"}, fb_msg_0, 7);
        check({tag, "_fb1"}, fb_msg_1, 7);
        check({tag, "_fb_idx"}, fb_min_index, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_min1"}, min1, 7);
        check({tag, "_min2"}, min2, 7);
        check({tag, "_min1_index"}, min1_index, 0);
`ifdef CNU_MIN2_INDEX_EN
        check({tag, "_min2_index"}, min2_index, 0);
`endif
    endtask

    initial begin
        #12;
        check_reset("rst");
        @(posedge sys_clk);
        #1 rstn = 1'b1;

        row = '{5, 3, 7, 6, 2, 4, 7, 7, 1, 6};
        send_row(row);
        check("r1_valid", out_valid, 1);
        check("r1_min1", min1, 1);
        check("r1_idx1", min1_index, 8);
        check("r1_min2", min2, 2);
`ifdef CNU_MIN2_INDEX_EN
        check("r1_idx2", min2_index, 4);
`endif

        row = '{0, 7, 7, 7, 7, 7, 7, 7, 7, 7};
        send_row(row);
        check("r2_valid", out_valid, 1);
        check("r2_min1", min1, 0);
        check("r2_idx1", min1_index, 0);
        check("r2_min2", min2, 7);

        row = '{7, 7, 7, 7, 7, 7, 7, 7, 5, 6};
        send_row(row);
        check("r3_valid", out_valid, 1);
        check("r3_min1", min1, 5);
        check("r3_idx1", min1_index, 8);
        check("r3_min2", min2, 6);
        @(posedge sys_clk);
        #1;
        check("r3_consumed", out_valid, 0);

        out_ready = 1'b0;
        row = '{5, 3, 7, 6, 2, 4, 7, 7, 1, 6};
        send_row(row);
        check("hold_valid", out_valid, 1);
        check("hold_ready", v2c_ready, 0);
        beat(0, 0);
        beat(0, 0);
        check("hold_min1", min1, 1);
        check("hold_idx1", min1_index, 8);
        check("hold_first", first_comp, 1);
        check("hold_valid2", out_valid, 1);
        out_ready = 1'b1;
        #1;
        check("hold_release_ready", v2c_ready, 1);
        @(posedge sys_clk);
        #1;
        check("hold_cleared", out_valid, 0);

        beat(0, 0);
        beat(0, 0);
        flush = 1'b1;
        beat(0, 0);
        flush = 1'b0;
        check("flush_first", first_comp, 1);
        check("flush_fb0", fb_msg_0, 7);
        check("flush_min1_kept", min1, 1);
        row = '{6, 6, 6, 6, 6, 6, 6, 6, 6, 3};
        send_row(row);
        check("r5_valid", out_valid, 1);
        check("r5_min1", min1, 3);
        check("r5_idx1", min1_index, 9);
        check("r5_min2", min2, 6);

        beat(0, 0);
        beat(1, 1);
        beat(2, 2);
        v2c_valid = 1'b1;
        #2 rstn = 1'b0;
        #1;
        v2c_valid = 1'b0;
        check_reset("midrst");
        @(posedge sys_clk);
        #1 rstn = 1'b1;
        row = '{5, 3, 7, 6, 2, 4, 7, 7, 1, 6};
        send_row(row);
        check("r6_valid", out_valid, 1);
        check("r6_min1", min1, 1);
        check("r6_idx1", min1_index, 8);
        check("r6_min2", min2, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
